// File: rtl/pipe_wb_regfile_if.sv
// rtl/pipe_wb_regfile_if.sv - MEM/WB write-back, ID read-port and commit-record bundle
interface pipe_wb_regfile_if #(
  parameter int NREG = 32,
  parameter int DW   = 32
);
  localparam int AW = $clog2(NREG);

  logic          wwreg;
  logic          wm2reg;
  logic [AW-1:0] wrn;
  logic [DW-1:0] wmo;
  logic [DW-1:0] walu;
  logic [AW-1:0] rna;
  logic [AW-1:0] rnb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic [DW-1:0] wdi;
  logic          cv;
  logic [AW-1:0] crn;
  logic [DW-1:0] cdata;

  modport master (
    output wwreg, wm2reg, wrn, wmo, walu, rna, rnb,
    input  qa, qb, wdi, cv, crn, cdata
  );

  modport slave (
    input  wwreg, wm2reg, wrn, wmo, walu, rna, rnb,
    output qa, qb, wdi, cv, crn, cdata
  );
endinterface

// File: rtl/pipe_wb_regfile.sv
// rtl/pipe_wb_regfile.sv - write-back mux, 32x32 register file with write-through reads, commit record
// Optional WB_STATS_EN adds the wcount committed-write counter.
module pipe_wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic              clock,
  input  logic              reset,
  pipe_wb_regfile_if.slave  wb
`ifdef WB_STATS_EN
  ,
  output logic [31:0]       wcount
`endif
);
  localparam int AW = $clog2(NREG);

  logic [DW-1:0] regs [NREG];
  logic          we;
  logic [DW-1:0] wdi;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic          cv;
  logic [AW-1:0] crn;
  logic [DW-1:0] cdata;

  always_comb begin
    wdi = wb.wm2reg ? wb.wmo : wb.walu;
  end

  // Gating with reset also disables the bypass while reset is held.
  assign we = wb.wwreg & (wb.wrn != '0) & ~reset;

  always_comb begin
    qa = '0;
    if (wb.rna != '0) begin
      if (we && (wb.wrn == wb.rna)) begin
        qa = wdi;
      end else begin
        qa = regs[wb.rna];
      end
    end
  end

  always_comb begin
    qb = '0;
    if (wb.rnb != '0) begin
      if (we && (wb.wrn == wb.rnb)) begin
        qb = wdi;
      end else begin
        qb = regs[wb.rnb];
      end
    end
  end

  // regs[0] is cleared by reset and never written since we excludes wrn=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wb.wrn] <= wdi;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cv    <= 1'b0;
      crn   <= '0;
      cdata <= '0;
    end else begin
      cv    <= we;
      crn   <= we ? wb.wrn : '0;
      cdata <= we ? wdi : '0;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wcount <= '0;
    end else if (we) begin
      wcount <= wcount + 32'd1;
    end
  end
`endif

  assign wb.wdi   = wdi;
  assign wb.qa    = qa;
  assign wb.qb    = qb;
  assign wb.cv    = cv;
  assign wb.crn   = crn;
  assign wb.cdata = cdata;
endmodule

// File: tb/tb_pipe_wb_regfile.sv
// tb/tb_pipe_wb_regfile.sv - randomized bench for pipe_wb_regfile against an architectural register model
module tb_pipe_wb_regfile;
  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  pipe_wb_regfile_if #(.NREG(32), .DW(32)) wb ();

`ifdef WB_STATS_EN
  logic [31:0] wcount;
`endif

  pipe_wb_regfile #(.NREG(32), .DW(32)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
`ifdef WB_STATS_EN
    ,
    .wcount(wcount)
`endif
  );

  // Architectural state as seen by software: register contents plus last commit.
  logic [31:0] m_regs [32];
  logic        m_cv;
  logic [4:0]  m_crn;
  logic [31:0] m_cdata;
  logic [31:0] m_cnt;
  bit          m_known = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit commits();
    return (wb.wwreg === 1'b1) && (wb.wrn != 5'd0) && (reset === 1'b0);
  endfunction

  function automatic logic [31:0] sel_data();
    return wb.wm2reg ? wb.wmo : wb.walu;
  endfunction

  // A read returns the register as it stands once this cycle's commit lands.
  function automatic logic [31:0] read_exp(input logic [4:0] rn);
    logic [31:0] after [32];
    after = m_regs;
    if (commits()) after[wb.wrn] = sel_data();
    return (rn == 5'd0) ? 32'd0 : after[rn];
  endfunction

  task automatic drive(input logic rst, input logic wr, input logic m2r, input logic [4:0] rn,
                       input logic [31:0] mo, input logic [31:0] alu,
                       input logic [4:0] a, input logic [4:0] b);
    reset     = rst;
    wb.wwreg  = wr;
    wb.wm2reg = m2r;
    wb.wrn    = rn;
    wb.wmo    = mo;
    wb.walu   = alu;
    wb.rna    = a;
    wb.rnb    = b;
    #1;
    if (m_known) begin
      check("wdi", wb.wdi, sel_data());
      check("qa", wb.qa, read_exp(wb.rna));
      check("qb", wb.qb, read_exp(wb.rnb));
    end
  endtask

  task automatic tick();
    bit          c  = commits();
    logic [4:0]  rn = wb.wrn;
    logic [31:0] wd = sel_data();
    bit          r  = (reset === 1'b1);
    @(posedge clock);
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_cv = 0; m_crn = 5'd0; m_cdata = 32'd0; m_cnt = 32'd0;
      m_known = 1;
    end else begin
      m_cv    = c;
      m_crn   = c ? rn : 5'd0;
      m_cdata = c ? wd : 32'd0;
      if (c) begin
        m_regs[rn] = wd;
        m_cnt = m_cnt + 32'd1;
      end
    end
    #1;
    if (m_known) begin
      check("cv", {31'd0, wb.cv}, {31'd0, m_cv});
      check("crn", {27'd0, wb.crn}, {27'd0, m_crn});
      check("cdata", wb.cdata, m_cdata);
`ifdef WB_STATS_EN
      check("wcount", wcount, m_cnt);
`endif
    end
  endtask

  initial begin
    logic [4:0]  rn;
    logic [4:0]  a;
    logic [4:0]  b;

    // Reset held two cycles with a write pending.
    drive(1, 1, 0, 5'd5, 32'd0, 32'h1234, 5'd5, 5'd5);
    tick();
    drive(1, 1, 0, 5'd5, 32'd0, 32'h1234, 5'd5, 5'd5);
    check("tp_rst_qa", wb.qa, 32'd0);
    tick();
    check("tp_rst_cv", {31'd0, wb.cv}, 32'd0);
    drive(0, 0, 0, 5'd5, 32'd0, 32'h1234, 5'd5, 5'd0);
    check("tp_rst_after_qa", wb.qa, 32'd0);
    tick();

    // ALU write-back.
    drive(0, 1, 0, 5'd8, 32'h11111111, 32'hDEADBEEF, 5'd1, 5'd2);
    check("tp_alu_wdi", wb.wdi, 32'hDEADBEEF);
    tick();
    check("tp_alu_cv", {31'd0, wb.cv}, 32'd1);
    check("tp_alu_crn", {27'd0, wb.crn}, 32'd8);
    check("tp_alu_cdata", wb.cdata, 32'hDEADBEEF);
    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd0);
    check("tp_alu_read", wb.qa, 32'hDEADBEEF);
    tick();

    // Load write-back seen through the bypass, then from storage.
    drive(0, 1, 1, 5'd9, 32'hCAFEF00D, 32'h0, 5'd9, 5'd9);
    check("tp_byp_qa", wb.qa, 32'hCAFEF00D);
    check("tp_byp_qb", wb.qb, 32'hCAFEF00D);
    tick();
    drive(0, 0, 0, 5'd9, 32'd0, 32'd0, 5'd9, 5'd9);
    check("tp_store_qa", wb.qa, 32'hCAFEF00D);
    tick();

    // Write to r0 is discarded.
    drive(0, 1, 0, 5'd0, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("tp_r0_qa", wb.qa, 32'd0);
    tick();
    check("tp_r0_cv", {31'd0, wb.cv}, 32'd0);
    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    check("tp_r0_after", wb.qa, 32'd0);
    tick();

    // Disabled write leaves the prior value.
    drive(0, 1, 0, 5'd3, 32'd0, 32'h77, 5'd0, 5'd0);
    tick();
    drive(0, 0, 0, 5'd3, 32'd0, 32'h55, 5'd3, 5'd0);
    check("tp_dis_qa", wb.qa, 32'h77);
    tick();
    check("tp_dis_cv", {31'd0, wb.cv}, 32'd0);

`ifdef WB_STATS_EN
    drive(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 1, 0, 5'(i), 32'd0, $urandom, 5'd0, 5'(i));
      tick();
    end
    drive(0, 1, 0, 5'd0, 32'd0, 32'd1, 5'd0, 5'd0);
    tick();
    drive(0, 1, 1, 5'd0, 32'd2, 32'd0, 5'd0, 5'd0);
    tick();
    drive(0, 0, 0, 5'd4, 32'd0, 32'd3, 5'd0, 5'd0);
    tick();
    check("tp_stats_cnt", wcount, 32'd10);
    drive(1, 1, 0, 5'd4, 32'd0, 32'd3, 5'd0, 5'd0);
    tick();
    check("tp_stats_rst", wcount, 32'd0);
`endif

    // Randomized traffic with occasional reset and frequent address collisions.
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? rn : 5'($urandom);
      b  = ($urandom_range(0, 2) == 0) ? rn : (($urandom_range(0, 3) == 0) ? a : 5'($urandom));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            rn, $urandom, $urandom, a, b);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_wb_regfile.md
Name: pipe_wb_regfile

Overview:
- Write-back end of the 5-stage pipeline. Consumes the MEM/WB register outputs (wwreg, wm2reg, wmo, walu, wrn) and selects the write-back value.
- Commits that value into the 32x32 general register file.
- Serves the ID stage's two combinational read ports, with same-cycle write-through bypass.
- Also produces a registered commit record for debug and trace.

Parameters:
- NREG, 32, number of architectural registers; also sets the address width of 5 bits. Fixed at 32.
- DW, 32, datapath width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wwreg  in  1  write-back enable from the MEM/WB register.
- wm2reg  in  1  1 = write memory data, 0 = write ALU result.
- wrn  in  5  destination register number.
- wmo  in  32  memory load data.
- walu  in  32  ALU result.
- rna  in  5  read port A address (ID stage rs).
- rnb  in  5  read port B address (ID stage rt).
- qa  out  32  read port A data.
- qb  out  32  read port B data.
- wdi  out  32  selected write-back data: wm2reg ? wmo : walu. Combinational.
- cv  out  1  commit valid; registered.
- crn  out  5  committed register number; registered.
- cdata  out  32  committed data; registered.

Behaviour:
- Write-back mux: wdi = wm2reg ? wmo : walu. Purely combinational, always driven, independent of wwreg.
- Commit condition: we = wwreg & (wrn != 0) & ~reset.
  - On the rising edge with we = 1: regs[wrn] <= wdi.
  - All other registers hold.
- Register 0:
  - Never written; reads as 0 always.
  - wwreg=1 with wrn=0 is silently discarded. No commit record: cv=0.
- Reads are combinational:
  - qa = (rna == 0) ? 0 : (we && wrn == rna) ? wdi : regs[rna]. qb is identical using rnb.
  - The bypass gives the same-cycle value being written, so an ID-stage read of a register committing in W this cycle sees the new value. There is no one-cycle gap.
- Both ports reading the same address, or both matching wrn: both get the bypassed wdi.
- Commit record, updated every rising edge:
  - cv <= we, crn <= we ? wrn : 0, cdata <= we ? wdi : 0.
  - One-cycle latency from the write edge; the record shows exactly the previous cycle's commit.
- Reset (synchronous, active-high), on a rising edge with reset=1:
  - All regs <= 0; cv <= 0, crn <= 0, cdata <= 0.
  - Any write presented that cycle is dropped.
  - While reset is held, the bypass is disabled (we=0), so qa/qb return stored values, which are 0 after the first reset edge.
- Reset mid-stream: a write in the same cycle as reset is lost. The first write accepted is the one on the first edge with reset=0.
- X-safety: wrn/wdi are ignored when wwreg=0; no register changes.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined:
  - Adds output wcount [31:0], a count of committed writes.
  - Increments by 1 on each edge with we=1; wraps from 0xFFFFFFFF to 0.
  - Cleared to 0 by reset.
  - Discarded r0 writes do not count.
- Undefined:
  - Port wcount and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold reset=1 two cycles with wwreg=1, wrn=5, walu=0x1234 -> regs[5]=0, qa(rna=5)=0, cv=0, crn=0, cdata=0 during and after reset.
- ALU write-back: wwreg=1, wm2reg=0, wrn=8, walu=0xDEADBEEF, wmo=0x11111111 -> wdi=0xDEADBEEF; next cycle cv=1, crn=8, cdata=0xDEADBEEF; later read rna=8 returns 0xDEADBEEF.
- Load write-back with bypass: wwreg=1, wm2reg=1, wrn=9, wmo=0xCAFEF00D, rna=rnb=9 in the same cycle -> qa=qb=0xCAFEF00D before the edge; after the edge, with wwreg=0, still 0xCAFEF00D from storage.
- r0 guard: wwreg=1, wrn=0, walu=0xFFFFFFFF -> qa(rna=0)=0 in the same cycle and after; next cycle cv=0; wcount unchanged when WB_STATS_EN is defined.
- Disabled write: wwreg=0, wrn=3, walu=0x55 -> regs[3] keeps its prior value (0x77 written earlier); cv=0; qa(rna=3)=0x77 with no bypass.
- Stats (WB_STATS_EN): 10 back-to-back commits to regs 1..10, plus 2 writes to r0 and 1 with wwreg=0 -> wcount=10; assert reset -> wcount=0.
